// File: rtl/mpu_collector.sv
`default_nettype none
// ============================================================================
// Module   : mpu_collector
// Purpose  : Collects row/col-tagged FMA results into an m x n matrix buffer.
//            Once every element has arrived, the matrix is written to the
//            matrix register file and completion is reported.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_collector #(
  parameter int FP               = 32,
  parameter int M                = 3,
  parameter int N                = 3,
  parameter int MATRIX_REGISTERS = 8,
  localparam int MATRIX_REG_BITS = $clog2(MATRIX_REGISTERS) - 1,
  localparam int MBITS           = $clog2(M + 1) - 1,
  localparam int NBITS           = $clog2(N + 1) - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_in,
  input  logic [MATRIX_REG_BITS:0]   dest_in,
  input  logic [MBITS:0]             m_in,
  input  logic [NBITS:0]             n_in,
  output logic                       busy_out,
  input  logic                       result_valid_in,
  output logic                       result_ready_out,
  input  logic [FP-1:0]              result_in,
  input  logic [MBITS:0]             result_row_in,
  input  logic [NBITS:0]             result_col_in,
  input  logic                       result_err_in,
  output logic                       reg_write_req_out,
  input  logic                       reg_write_ack_in,
  output logic [MATRIX_REG_BITS:0]   reg_write_addr_out,
  output logic [MBITS:0]             reg_write_m_out,
  output logic [NBITS:0]             reg_write_n_out,
  output logic [M*N*FP-1:0]          reg_write_matrix_out,
  output logic                       done_out,
  output logic                       error_out
);

  localparam int ELEMS = M * N;
  localparam int IDXW  = $clog2(ELEMS + 1);
  localparam int MW    = MBITS + 1;
  localparam int NW    = NBITS + 1;
  localparam logic [MBITS:0] M_MAX = MW'(M);
  localparam logic [NBITS:0] N_MAX = NW'(N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ELEMS-1:0]           bitmap_q, bitmap_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [MATRIX_REG_BITS:0]   dest_q;
  logic [MBITS:0]             m_q;
  logic [NBITS:0]             n_q;
  logic [FP-1:0]              buf_q [ELEMS];

  logic                       w_legal;
  logic                       w_accept_start;
  logic                       w_wr_en;
  logic                       w_in_range;
  logic                       w_dup;
  logic [IDXW-1:0]            w_idx;
  logic [IDXW-1:0]            w_total;
  logic [ELEMS-1:0]           w_onehot;
  logic [ELEMS-1:0]           w_mask;

  assign w_legal    = (m_in != '0) && (n_in != '0) && (m_in <= M_MAX) && (n_in <= N_MAX);
  assign w_in_range = (result_row_in < m_q) && (result_col_in < n_q);
  assign w_idx      = IDXW'(result_row_in) * IDXW'(n_q) + IDXW'(result_col_in);
  assign w_total    = IDXW'(m_q) * IDXW'(n_q);
  assign w_dup      = |(bitmap_q & w_onehot);

  // Decode the element index into a one-hot slot select and build the completion mask.
  always_comb begin
    w_onehot = '0;
    w_mask   = '0;
    for (int i = 0; i < ELEMS; i++) begin
      w_onehot[i] = (w_idx == IDXW'(i));
      w_mask[i]   = (IDXW'(i) < w_total);
    end
  end

  // Next-state logic: job acceptance, result gathering and write handshake.
  always_comb begin
    state_d        = state_q;
    bitmap_d       = bitmap_q;
    err_d          = err_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    w_accept_start = 1'b0;
    w_wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (w_legal) begin
            w_accept_start = 1'b1;
            bitmap_d       = '0;
            err_d          = 1'b0;
            state_d        = ST_GATHER;
          end else begin
            // Malformed job: report failure at once without touching the register file.
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      ST_GATHER: begin
        if (result_valid_in) begin
          err_d = err_q | result_err_in;
          if (!w_in_range || w_dup) begin
            // Out-of-range and duplicate results are dropped; the first value wins.
            err_d = 1'b1;
          end else begin
            w_wr_en  = 1'b1;
            bitmap_d = bitmap_q | w_onehot;
            if ((bitmap_q | w_onehot) == w_mask) begin
              state_d = ST_WRITE;
            end
          end
        end
      end
      ST_WRITE: begin
        if (reg_write_ack_in) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          error_d = err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, bitmap, status and latched job fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitmap_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      dest_q   <= '0;
      m_q      <= '0;
      n_q      <= '0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
      done_q   <= done_d;
      error_q  <= error_d;
      if (w_accept_start) begin
        dest_q <= dest_in;
        m_q    <= m_in;
        n_q    <= n_in;
      end
    end
  end

  // Matrix buffer: cleared on job start, written once per accepted element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ELEMS; i++) buf_q[i] <= '0;
    end else if (w_accept_start) begin
      for (int i = 0; i < ELEMS; i++) buf_q[i] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < ELEMS; i++) begin
        if (w_onehot[i]) buf_q[i] <= result_in;
      end
    end
  end

  // Element 0 occupies the most significant slot of the packed matrix.
  for (genvar gi = 0; gi < ELEMS; gi++) begin : g_pack
    assign reg_write_matrix_out[(ELEMS-1-gi)*FP +: FP] = buf_q[gi];
  end

  assign busy_out           = (state_q != ST_IDLE);
  assign result_ready_out   = (state_q == ST_GATHER);
  assign reg_write_req_out  = (state_q == ST_WRITE);
  assign reg_write_addr_out = dest_q;
  assign reg_write_m_out    = m_q;
  assign reg_write_n_out    = n_q;
  assign done_out           = done_q;
  assign error_out          = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mpu_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpu_collector
// Purpose  : Directed self-checking bench for mpu_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mpu_collector;

  localparam int MATW = 288;

  logic             clk;
  logic             rst_n;
  logic             start_in;
  logic [2:0]       dest_in;
  logic [1:0]       m_in;
  logic [1:0]       n_in;
  logic             busy_out;
  logic             result_valid_in;
  logic             result_ready_out;
  logic [31:0]      result_in;
  logic [1:0]       result_row_in;
  logic [1:0]       result_col_in;
  logic             result_err_in;
  logic             reg_write_req_out;
  logic             reg_write_ack_in;
  logic [2:0]       reg_write_addr_out;
  logic [1:0]       reg_write_m_out;
  logic [1:0]       reg_write_n_out;
  logic [MATW-1:0]  reg_write_matrix_out;
  logic             done_out;
  logic             error_out;

  int n_cmp;
  int n_bad;
  logic [31:0]     fv [10];
  logic [MATW-1:0] exp_mat;

  mpu_collector dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start_in             (start_in),
    .dest_in              (dest_in),
    .m_in                 (m_in),
    .n_in                 (n_in),
    .busy_out             (busy_out),
    .result_valid_in      (result_valid_in),
    .result_ready_out     (result_ready_out),
    .result_in            (result_in),
    .result_row_in        (result_row_in),
    .result_col_in        (result_col_in),
    .result_err_in        (result_err_in),
    .reg_write_req_out    (reg_write_req_out),
    .reg_write_ack_in     (reg_write_ack_in),
    .reg_write_addr_out   (reg_write_addr_out),
    .reg_write_m_out      (reg_write_m_out),
    .reg_write_n_out      (reg_write_n_out),
    .reg_write_matrix_out (reg_write_matrix_out),
    .done_out             (done_out),
    .error_out            (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MATW-1:0] obs, input logic [MATW-1:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [MATW-1:0] mat_set(input logic [MATW-1:0] mat, input int idx,
                                              input logic [31:0] v);
    mat[(8-idx)*32 +: 32] = v;
    return mat;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [2:0] d, input logic [1:0] m, input logic [1:0] n);
    dest_in  = d;
    m_in     = m;
    n_in     = n;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic send(input logic [1:0] r, input logic [1:0] c, input logic [31:0] v, input logic e);
    result_row_in   = r;
    result_col_in   = c;
    result_in       = v;
    result_err_in   = e;
    result_valid_in = 1'b1;
    tick();
    result_valid_in = 1'b0;
    result_err_in   = 1'b0;
  endtask

  task automatic ack_write();
    reg_write_ack_in = 1'b1;
    tick();
    reg_write_ack_in = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic exp_err);
    check({tag, ".done"}, MATW'(done_out), MATW'(1'b1));
    check({tag, ".error"}, MATW'(error_out), MATW'(exp_err));
    check({tag, ".req_drop"}, MATW'(reg_write_req_out), '0);
    check({tag, ".idle"}, MATW'(busy_out), '0);
    tick();
    check({tag, ".done_clr"}, MATW'({done_out, error_out}), '0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"}, MATW'(busy_out), '0);
    check({tag, ".ready"}, MATW'(result_ready_out), '0);
    check({tag, ".req"}, MATW'(reg_write_req_out), '0);
    check({tag, ".fields"}, MATW'({reg_write_addr_out, reg_write_m_out, reg_write_n_out}), '0);
    check({tag, ".matrix"}, reg_write_matrix_out, '0);
    check({tag, ".done_err"}, MATW'({done_out, error_out}), '0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fv[0] = 32'h00000000; fv[1] = 32'h3f800000; fv[2] = 32'h40000000;
    fv[3] = 32'h40400000; fv[4] = 32'h40800000; fv[5] = 32'h40a00000;
    fv[6] = 32'h40c00000; fv[7] = 32'h40e00000; fv[8] = 32'h41000000;
    fv[9] = 32'h41100000;

    rst_n = 1'b0; start_in = 1'b0; dest_in = '0; m_in = '0; n_in = '0;
    result_valid_in = 1'b0; result_in = '0; result_row_in = '0; result_col_in = '0;
    result_err_in = 1'b0; reg_write_ack_in = 1'b0;
    #3;
    check_zero_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: full 3x3 job, in-order results
    start_job(3'd5, 2'd3, 2'd3);
    check("t1.busy", MATW'(busy_out), MATW'(1'b1));
    check("t1.ready", MATW'(result_ready_out), MATW'(1'b1));
    exp_mat = '0;
    for (int i = 0; i < 9; i++) begin
      send(2'(i / 3), 2'(i % 3), fv[i+1], 1'b0);
      exp_mat = mat_set(exp_mat, i, fv[i+1]);
      if (i == 7) check("t1.no_early_req", MATW'(reg_write_req_out), '0);
    end
    check("t1.req", MATW'(reg_write_req_out), MATW'(1'b1));
    check("t1.ready_low", MATW'(result_ready_out), '0);
    check("t1.addr_m_n", MATW'({reg_write_addr_out, reg_write_m_out, reg_write_n_out}),
          MATW'({3'd5, 2'd3, 2'd3}));
    check("t1.matrix", reg_write_matrix_out, exp_mat);
    ack_write();
    check_done("t1", 1'b0);

    // 2: 2x2 job, out-of-order results, unused slots zero
    start_job(3'd1, 2'd2, 2'd2);
    send(2'd1, 2'd1, fv[4], 1'b0);
    send(2'd0, 2'd0, fv[1], 1'b0);
    send(2'd1, 2'd0, fv[3], 1'b0);
    send(2'd0, 2'd1, fv[2], 1'b0);
    exp_mat = '0;
    for (int i = 0; i < 4; i++) exp_mat = mat_set(exp_mat, i, fv[i+1]);
    check("t2.req", MATW'(reg_write_req_out), MATW'(1'b1));
    check("t2.matrix", reg_write_matrix_out, exp_mat);
    ack_write();
    check_done("t2", 1'b0);

    // 3: duplicate and out-of-range results
    start_job(3'd0, 2'd3, 2'd3);
    send(2'd0, 2'd0, fv[7], 1'b0);
    send(2'd0, 2'd0, fv[8], 1'b0);
    send(2'd2, 2'd3, fv[9], 1'b0);
    check("t3.still_gather", MATW'({busy_out, reg_write_req_out}), MATW'(2'b10));
    exp_mat = mat_set('0, 0, fv[7]);
    for (int i = 1; i < 9; i++) begin
      send(2'(i / 3), 2'(i % 3), fv[i+1], 1'b0);
      exp_mat = mat_set(exp_mat, i, fv[i+1]);
    end
    check("t3.req", MATW'(reg_write_req_out), MATW'(1'b1));
    check("t3.matrix", reg_write_matrix_out, exp_mat);
    ack_write();
    check_done("t3", 1'b1);

    // 4: 2x3 job with one flagged result and a delayed ack
    start_job(3'd3, 2'd2, 2'd3);
    exp_mat = '0;
    for (int i = 0; i < 6; i++) begin
      send(2'(i / 3), 2'(i % 3), fv[i+1], (i == 4));
      exp_mat = mat_set(exp_mat, i, fv[i+1]);
    end
    for (int k = 0; k < 5; k++) begin
      check("t4.req_held", MATW'(reg_write_req_out), MATW'(1'b1));
      check("t4.fields_held", MATW'({reg_write_addr_out, reg_write_m_out, reg_write_n_out}),
            MATW'({3'd3, 2'd2, 2'd3}));
      check("t4.matrix_held", reg_write_matrix_out, exp_mat);
      tick();
    end
    ack_write();
    check_done("t4", 1'b1);

    // 5: illegal start, stray ack in IDLE, start ignored during GATHER
    start_job(3'd6, 2'd0, 2'd2);
    check("t5.no_gather", MATW'({busy_out, reg_write_req_out}), '0);
    check_done("t5.bad_m", 1'b1);
    reg_write_ack_in = 1'b1;
    tick();
    reg_write_ack_in = 1'b0;
    check("t5.stray_ack", MATW'({done_out, busy_out}), '0);
    start_job(3'd2, 2'd2, 2'd2);
    start_job(3'd7, 2'd1, 2'd1);
    check("t5.restart_ignored", MATW'({busy_out, reg_write_addr_out, reg_write_m_out, reg_write_n_out}),
          MATW'({1'b1, 3'd2, 2'd2, 2'd2}));
    exp_mat = '0;
    for (int i = 0; i < 4; i++) begin
      send(2'(i / 2), 2'(i % 2), fv[i+5], 1'b0);
      exp_mat = mat_set(exp_mat, i, fv[i+5]);
    end
    check("t5.matrix", reg_write_matrix_out, exp_mat);
    ack_write();
    check_done("t5", 1'b0);

    // 6: asynchronous reset mid-job, then a clean job
    start_job(3'd6, 2'd3, 2'd3);
    for (int i = 0; i < 4; i++) send(2'(i / 3), 2'(i % 3), fv[i+1], 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6.reset");
    tick();
    rst_n = 1'b1;
    tick();
    check("t6.no_write", MATW'(reg_write_req_out), '0);
    start_job(3'd4, 2'd3, 2'd3);
    exp_mat = '0;
    for (int i = 0; i < 9; i++) begin
      send(2'(i / 3), 2'(i % 3), fv[9-i], 1'b0);
      exp_mat = mat_set(exp_mat, i, fv[9-i]);
    end
    check("t6.req", MATW'({reg_write_req_out, reg_write_addr_out}), MATW'({1'b1, 3'd4}));
    check("t6.matrix", reg_write_matrix_out, exp_mat);
    ack_write();
    check_done("t6", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
